// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module : mc_pkg
// Brief  : State encoding, opcodes and control-field codes for the multi-cycle control FSM.
// Rev    : 1.0  initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_ERROR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that stall on the memory handshake and therefore feed the timeout counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDI_WB);
    endfunction

endpackage : mc_pkg
`default_nettype wire

// File: rtl/multicycle_control_out_decode.sv
`default_nettype none
// ============================================================================
// Module : mc_out_decode
// Brief  : Combinational map from FSM state (and mem_ready in FETCH) to the datapath control vector.
// Rev    : 1.0  initial release
// ============================================================================
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                // PC and IR only update once the instruction word has actually arrived.
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_SEXT_SH2;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : mc_out_decode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control
// Brief  : Multi-cycle MIPS control FSM with memory-ready stalls, retire counter and error pulses.
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_control
    import mc_pkg::*;
#(
    parameter int EN_ADDI  = 1,
    parameter int EN_JUMP  = 1,
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_code,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [3:0]       state_dbg
);

    localparam int            WW         = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] C_WAIT_LIM = WW'(WAIT_MAX);

    state_t           state_q,   state_d;
    logic [WW-1:0]    wait_q,    wait_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             is_sw_q,   is_sw_d;
    logic             timeout_q, timeout_d;

    logic  w_wait_expired;
    logic  w_retire;
    ctrl_t w_ctrl;
    ctrl_t w_ctrl_out;

    assign w_wait_expired = (WAIT_MAX != 0) && (wait_q == C_WAIT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            count_q   <= '0;
            is_sw_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            is_sw_q   <= is_sw_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        timeout_d = timeout_q;
        wait_d    = '0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d   = (op_code == OP_SW);
                timeout_d = 1'b0;
                case (op_code)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = (EN_JUMP != 0) ? S_JUMP : S_ERROR;
                    OP_ADDI:      state_d = (EN_ADDI != 0) ? S_ADDI_EX : S_ERROR;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            // Single-cycle terminal states, ERROR and the unused encodings all return to FETCH.
            default:   state_d = S_FETCH;
        endcase
        // A ready handshake in the same cycle as an expired count takes the normal path.
        if (is_wait_state(state_q) && !mem_ready) begin
            if (w_wait_expired) begin
                state_d   = S_ERROR;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end
    end

    assign w_retire = is_retire_state(state_q) && (state_d == S_FETCH);
    assign count_d  = w_retire ? count_q + CNT_W'(1) : count_q;

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (w_ctrl)
    );

    always_comb begin
        w_ctrl_out  = rst ? '0 : w_ctrl;
        instr_done  = w_retire && !rst;
        err_illegal = (state_q == S_ERROR) && !timeout_q && !rst;
        err_timeout = (state_q == S_ERROR) &&  timeout_q && !rst;
    end

    assign PCWrite     = w_ctrl_out.pc_write;
    assign PCWriteCond = w_ctrl_out.pc_write_cond;
    assign IorD        = w_ctrl_out.i_or_d;
    assign MemRead     = w_ctrl_out.mem_read;
    assign MemWrite    = w_ctrl_out.mem_write;
    assign MemtoReg    = w_ctrl_out.mem_to_reg;
    assign IRWrite     = w_ctrl_out.ir_write;
    assign ALUSrcA     = w_ctrl_out.alu_src_a;
    assign RegWrite    = w_ctrl_out.reg_write;
    assign RegDst      = w_ctrl_out.reg_dst;
    assign ALUSrcB     = w_ctrl_out.alu_src_b;
    assign ALUOp       = w_ctrl_out.alu_op;
    assign PCSource    = w_ctrl_out.pc_source;
    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Self-checking bench: directed vector table, corner sequences and a random run vs. a path model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] op_code = 6'd0;
    always #5 clk = ~clk;

    logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw, a_srca, a_rw, a_rd, a_done, a_ill, a_tmo;
    logic [1:0] a_srcb, a_aluop, a_pcsrc;
    logic [31:0] a_cnt;
    logic [3:0] a_st;
    logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_m2r, b_irw, b_srca, b_rw, b_rd, b_done, b_ill, b_tmo;
    logic [1:0] b_srcb, b_aluop, b_pcsrc;
    logic [2:0] b_cnt;
    logic [3:0] b_st;

    multicycle_control #(.EN_ADDI(1), .EN_JUMP(1), .CNT_W(32), .WAIT_MAX(15)) dut_a (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw),
        .MemtoReg(a_m2r), .IRWrite(a_irw), .ALUSrcA(a_srca), .RegWrite(a_rw), .RegDst(a_rd),
        .ALUSrcB(a_srcb), .ALUOp(a_aluop), .PCSource(a_pcsrc), .instr_done(a_done),
        .instr_count(a_cnt), .err_illegal(a_ill), .err_timeout(a_tmo), .state_dbg(a_st));

    multicycle_control #(.EN_ADDI(0), .EN_JUMP(0), .CNT_W(3), .WAIT_MAX(2)) dut_b (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw),
        .MemtoReg(b_m2r), .IRWrite(b_irw), .ALUSrcA(b_srca), .RegWrite(b_rw), .RegDst(b_rd),
        .ALUSrcB(b_srcb), .ALUOp(b_aluop), .PCSource(b_pcsrc), .instr_done(b_done),
        .instr_count(b_cnt), .err_illegal(b_ill), .err_timeout(b_tmo), .state_dbg(b_st));

    logic [1:0][15:0] act_ctrl;
    logic [1:0][31:0] act_cnt;
    logic [1:0][3:0]  act_st;
    logic [1:0]       act_done, act_ill, act_tmo;
    assign act_ctrl[0] = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw, a_srca, a_rw, a_rd, a_srcb, a_aluop, a_pcsrc};
    assign act_ctrl[1] = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_m2r, b_irw, b_srca, b_rw, b_rd, b_srcb, b_aluop, b_pcsrc};
    assign act_cnt[0]  = a_cnt;
    assign act_cnt[1]  = {29'd0, b_cnt};
    assign act_st[0]   = a_st;
    assign act_st[1]   = b_st;
    assign act_done    = {b_done, a_done};
    assign act_ill     = {b_ill, a_ill};
    assign act_tmo     = {b_tmo, a_tmo};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each instruction is a path of phases chosen at decode;
    // memory phases repeat while not ready, and the stall budget diverts to ERROR.
    int          m_cur[2];
    int          m_path[2][3];
    int          m_plen[2];
    int          m_pidx[2];
    int          m_wait[2];
    bit          m_tmo[2];
    logic [31:0] m_count[2];
    bit          m_valid = 1'b0;
    logic        cur_r = 1'b1;
    logic [5:0]  cur_op = 6'd0;
    logic        cur_rdy = 1'b1;

    function automatic int wait_max(input int i);
        return (i == 0) ? 15 : 2;
    endfunction

    function automatic logic [15:0] exp_ctrl(input int s, input logic rdy);
        case (s)
            0:       return rdy ? 16'h9210 : 16'h1010;
            1:       return 16'h0030;
            2, 10:   return 16'h0120;
            3:       return 16'h3000;
            4:       return 16'h0480;
            5:       return 16'h2800;
            6:       return 16'h0108;
            7:       return 16'h00C0;
            8:       return 16'h4105;
            9:       return 16'h8002;
            11:      return 16'h0080;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic set_path(input int i, input logic [5:0] op);
        m_plen[i] = 1;
        m_path[i][0] = 12;
        case (op)
            R_OP: begin m_path[i][0] = 6; m_path[i][1] = 7; m_plen[i] = 2; end
            LW:   begin m_path[i][0] = 2; m_path[i][1] = 3; m_path[i][2] = 4; m_plen[i] = 3; end
            SW:   begin m_path[i][0] = 2; m_path[i][1] = 5; m_plen[i] = 2; end
            BEQ:  m_path[i][0] = 8;
            JMP:  if (i == 0) m_path[i][0] = 9;
            ADDI: if (i == 0) begin m_path[i][0] = 10; m_path[i][1] = 11; m_plen[i] = 2; end
            default: ;
        endcase
        m_cur[i]  = m_path[i][0];
        m_pidx[i] = 1;
    endtask

    task automatic advance(input int i);
        if (cur_r) begin
            m_cur[i] = 0; m_count[i] = 0; m_wait[i] = 0; m_plen[i] = 0; m_pidx[i] = 0;
        end else if ((m_cur[i] inside {0, 3, 5}) && !cur_rdy) begin
            if (m_wait[i] == wait_max(i)) begin
                m_cur[i] = 12; m_tmo[i] = 1'b1; m_wait[i] = 0; m_pidx[i] = m_plen[i];
            end else begin
                m_wait[i]++;
            end
        end else begin
            m_wait[i] = 0;
            if (m_cur[i] == 0) m_cur[i] = 1;
            else if (m_cur[i] == 1) begin
                set_path(i, cur_op);
                if (m_cur[i] == 12) m_tmo[i] = 1'b0;
            end else if (m_pidx[i] < m_plen[i]) begin
                m_cur[i] = m_path[i][m_pidx[i]];
                m_pidx[i]++;
            end else begin
                if (m_cur[i] != 12) m_count[i]++;
                m_cur[i] = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
        cur_r = r; cur_op = op; cur_rdy = rdy;
        rst = r; op_code = op; mem_ready = rdy;
    endtask

    task automatic sample();
        logic ed;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ed = !cur_r && !(m_cur[i] inside {0, 1, 12}) && (m_pidx[i] >= m_plen[i]) &&
                 (m_cur[i] != 5 || cur_rdy);
            chk($sformatf("dut%0d ctrl", i), 32'(act_ctrl[i]), cur_r ? 32'd0 : 32'(exp_ctrl(m_cur[i], cur_rdy)));
            chk($sformatf("dut%0d instr_done", i), 32'(act_done[i]), 32'(ed));
            chk($sformatf("dut%0d err_illegal", i), 32'(act_ill[i]), 32'(!cur_r && m_cur[i] == 12 && !m_tmo[i]));
            chk($sformatf("dut%0d err_timeout", i), 32'(act_tmo[i]), 32'(!cur_r && m_cur[i] == 12 && m_tmo[i]));
            if (m_valid) begin
                chk($sformatf("dut%0d instr_count", i), act_cnt[i], (i == 0) ? m_count[i] : (m_count[i] & 32'h7));
                chk($sformatf("dut%0d state_dbg", i), 32'(act_st[i]), 32'(m_cur[i]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) advance(i);
        if (cur_r) m_valid = 1'b1;
        #1;
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic rdy);
        drive(r, op, rdy);
        sample();
        tick();
    endtask

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        int          st;
        logic [15:0] ctrl;
        logic        done;
        logic        ill;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input int st,
                       input logic [15:0] ctrl, input logic done, input logic ill, input int cnt);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.done = done; v.ill = ill; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return R_OP;
            1:       return LW;
            2:       return SW;
            3:       return BEQ;
            4:       return JMP;
            5:       return ADDI;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        // Expected values for the configuration with every opcode enabled (dut_a).
        repeat (3) add(1, R_OP, 1, 0, 16'h0000, 0, 0, 0);
        add(0, R_OP, 1, 0, 16'h9210, 0, 0, 0);
        add(0, R_OP, 1, 1, 16'h0030, 0, 0, 0);
        add(0, R_OP, 1, 6, 16'h0108, 0, 0, 0);
        add(0, R_OP, 1, 7, 16'h00C0, 1, 0, 0);
        add(0, LW,   1, 0, 16'h9210, 0, 0, 1);
        add(0, LW,   1, 1, 16'h0030, 0, 0, 1);
        add(0, LW,   1, 2, 16'h0120, 0, 0, 1);
        repeat (3) add(0, LW, 0, 3, 16'h3000, 0, 0, 1);
        add(0, LW,   1, 3, 16'h3000, 0, 0, 1);
        add(0, LW,   1, 4, 16'h0480, 1, 0, 1);
        add(0, SW,   1, 0, 16'h9210, 0, 0, 2);
        add(0, SW,   1, 1, 16'h0030, 0, 0, 2);
        add(0, SW,   1, 2, 16'h0120, 0, 0, 2);
        add(0, SW,   1, 5, 16'h2800, 1, 0, 2);
        add(0, BEQ,  1, 0, 16'h9210, 0, 0, 3);
        add(0, BEQ,  1, 1, 16'h0030, 0, 0, 3);
        add(0, BEQ,  1, 8, 16'h4105, 1, 0, 3);
        add(0, JMP,  1, 0, 16'h9210, 0, 0, 4);
        add(0, JMP,  1, 1, 16'h0030, 0, 0, 4);
        add(0, JMP,  1, 9, 16'h8002, 1, 0, 4);
        add(0, ADDI, 1, 0, 16'h9210, 0, 0, 5);
        add(0, ADDI, 1, 1, 16'h0030, 0, 0, 5);
        add(0, ADDI, 1, 10, 16'h0120, 0, 0, 5);
        add(0, ADDI, 1, 11, 16'h0080, 1, 0, 5);
        add(0, BAD,  1, 0, 16'h9210, 0, 0, 6);
        add(0, BAD,  1, 1, 16'h0030, 0, 0, 6);
        add(0, BAD,  1, 12, 16'h0000, 0, 1, 6);
        add(0, R_OP, 0, 0, 16'h1010, 0, 0, 6);
        add(0, R_OP, 1, 0, 16'h9210, 0, 0, 6);

        drive(1, R_OP, 1);
        tick();

        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].op, tbl[k].rdy);
            sample();
            chk($sformatf("vec%0d state", k), 32'(a_st), 32'(tbl[k].st));
            chk($sformatf("vec%0d ctrl", k), 32'(act_ctrl[0]), 32'(tbl[k].ctrl));
            chk($sformatf("vec%0d done", k), 32'(a_done), 32'(tbl[k].done));
            chk($sformatf("vec%0d illegal", k), 32'(a_ill), 32'(tbl[k].ill));
            chk($sformatf("vec%0d count", k), a_cnt, 32'(tbl[k].cnt));
            tick();
        end

        // FETCH stall with WAIT_MAX=2: three waits, then ERROR with err_timeout.
        repeat (2) step(1, R_OP, 1);
        for (int c = 0; c < 3; c++) begin
            drive(0, R_OP, 0);
            sample();
            chk("tmo stall state", 32'(b_st), 32'd0);
            tick();
        end
        drive(0, R_OP, 0);
        sample();
        chk("tmo err state", 32'(b_st), 32'd12);
        chk("tmo err_timeout", 32'(b_tmo), 32'd1);
        chk("tmo err_illegal", 32'(b_ill), 32'd0);
        chk("tmo long budget", 32'(a_st), 32'd0);
        tick();
        drive(0, R_OP, 1);
        sample();
        chk("tmo back to fetch", 32'(b_st), 32'd0);
        chk("tmo pulse width", 32'(b_tmo), 32'd0);
        tick();

        // Ready on the third wait cycle still advances; then j is illegal with jumps disabled.
        repeat (2) step(1, R_OP, 1);
        repeat (2) step(0, R_OP, 0);
        step(0, JMP, 1);
        drive(0, JMP, 1);
        sample();
        chk("late ready decode", 32'(b_st), 32'd1);
        tick();
        drive(0, JMP, 1);
        sample();
        chk("j disabled state", 32'(b_st), 32'd12);
        chk("j disabled err_illegal", 32'(b_ill), 32'd1);
        chk("j disabled err_timeout", 32'(b_tmo), 32'd0);
        chk("j enabled state", 32'(a_st), 32'd9);
        tick();
        drive(0, R_OP, 1);
        sample();
        chk("j disabled no retire", 32'(b_cnt), 32'd0);
        tick();

        // Nine branches on the 3-bit counter wrap 7 -> 0 -> 1.
        repeat (2) step(1, R_OP, 1);
        for (int k = 0; k < 9; k++) begin
            drive(0, BEQ, 1);
            sample();
            if (k == 8) chk("wrap to zero", 32'(b_cnt), 32'd0);
            tick();
            step(0, BEQ, 1);
            drive(0, BEQ, 1);
            sample();
            if (k == 8) chk("branch ctrl", 32'(act_ctrl[1]), 32'h4105);
            tick();
        end
        drive(0, R_OP, 1);
        sample();
        chk("wrap count", 32'(b_cnt), 32'd1);
        chk("wide count", a_cnt, 32'd9);
        tick();

        // Reset during a store wait aborts it without a retire pulse.
        repeat (2) step(1, R_OP, 1);
        repeat (3) step(0, SW, 1);
        drive(0, SW, 0);
        sample();
        chk("memwr reached", 32'(b_st), 32'd5);
        tick();
        drive(1, SW, 1);
        sample();
        chk("abort done a", 32'(a_done), 32'd0);
        chk("abort done b", 32'(b_done), 32'd0);
        chk("abort ctrl", 32'(act_ctrl[1]), 32'd0);
        tick();
        drive(0, SW, 1);
        sample();
        chk("abort state", 32'(b_st), 32'd0);
        chk("abort count", a_cnt, 32'd0);
        tick();

        // Random traffic: mostly-ready memory, then a slow memory that provokes timeouts.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0), rand_op(),
                 ($urandom_range(0, 99) < ((n < 1500) ? 75 : 30)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
